fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the pipelined datapath: program counter, variable-latency instruction-memory handshake and a prefetch buffer feeding the decode stage.
- Accepts taken-branch and jump redirects from later stages, flushes wrong-path instructions and discards in-flight responses.
- Replaces the bare PC register, PC+4 adder and next-PC muxes of the previous datapath.

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: program counter, single-outstanding
// instruction-memory handshake, prefetch buffer feeding decode, and
// branch/jump redirect handling with discard of in-flight responses.
module fetch_unit #(
  parameter int              XLEN         = 32,
  parameter int              IBUF_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            branch_valid,
  input  logic [XLEN-1:0] branch_pc4,
  input  logic [XLEN-1:0] branch_imm,
  input  logic            jump_valid,
  input  logic [XLEN-1:0] jump_pc4,
  input  logic [25:0]     jump_index,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc4,
  input  logic            dec_ready,
  output logic [15:0]     redirect_count
);

  localparam int PTR_W = $clog2(IBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IBUF_DEPTH);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  req_addr;   // address of the request being dropped
  logic             req_q;
  logic             drop;       // outstanding response belongs to a wrong path

  logic [XLEN-1:0]  buf_instr [IBUF_DEPTH];
  logic [XLEN-1:0]  buf_pc4   [IBUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  logic             xfer;
  logic             redirect;
  logic             push;
  logic             pop;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  branch_target;
  logic [XLEN-1:0]  jump_target;
  logic [XLEN-1:0]  target;

  // Only the upper PC bits take part in the jump target.
  logic unused_jump_low;
  assign unused_jump_low = ^jump_pc4[27:0];

  assign pc_plus4      = fetch_pc + XLEN'(4);
  assign branch_target = branch_pc4 + (branch_imm << 2);
  assign jump_target   = {jump_pc4[XLEN-1:28], jump_index, 2'b00};
  assign target        = jump_valid ? jump_target : branch_target;
  assign redirect      = jump_valid | branch_valid;

  // A transfer with a redirect at the same edge is wrong-path data.
  assign xfer = req_q & imem_ack;
  assign push = xfer & ~drop & ~redirect;
  assign pop  = if_valid & dec_ready & ~redirect;

  assign imem_req  = req_q;
  assign imem_addr = drop ? req_addr : fetch_pc;

  // Empty entries read as zero so the decode side never sees stale words.
  assign if_valid = (count != '0);
  assign if_instr = if_valid ? buf_instr[rd_ptr] : '0;
  assign if_pc4   = if_valid ? buf_pc4[rd_ptr]   : '0;

  // Occupancy after this edge's push/pop; a redirect empties the buffer.
  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    count_next = count;
    if (redirect) begin
      count_next = '0;
    end else begin
      count_next = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // PC, request, drop flag and buffer pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_VECTOR;
      req_addr <= RESET_VECTOR;
      req_q    <= 1'b0;
      drop     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      count <= count_next;
      req_q <= (count_next < DEPTH_C);

      // Freeze the presented address once it becomes a dropped request.
      if (!drop) begin
        req_addr <= fetch_pc;
      end

      if (redirect) begin
        fetch_pc <= target;
      end else if (push) begin
        fetch_pc <= pc_plus4;
      end

      if (redirect && req_q && !imem_ack) begin
        drop <= 1'b1;
      end else if (xfer) begin
        drop <= 1'b0;
      end

      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Buffer storage; validity is tracked by count alone.
  // NOTE: the data array carries no reset -- count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc4[wr_ptr]   <= pc_plus4;
    end
  end

  // Saturating count of applied redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_count <= '0;
    end else if (redirect && redirect_count != 16'hFFFF) begin
      redirect_count <= redirect_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a latency-programmable
// instruction memory whose data word is the address XOR 32'hDEAD_0000.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch_valid;
  logic [31:0] branch_pc4;
  logic [31:0] branch_imm;
  logic        jump_valid;
  logic [31:0] jump_pc4;
  logic [25:0] jump_index;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        dec_ready;
  logic [15:0] redirect_count;

  int vectors    = 0;
  int miscompares = 0;
  int lat        = 0;   // cycles of wait before the ack cycle
  int wait_cnt   = 0;
  int ack_count  = 0;
  logic force_ack = 1'b0;

  fetch_unit #(
    .XLEN(32),
    .IBUF_DEPTH(4),
    .RESET_VECTOR(32'h0000_0040)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .branch_valid(branch_valid),
    .branch_pc4(branch_pc4),
    .branch_imm(branch_imm),
    .jump_valid(jump_valid),
    .jump_pc4(jump_pc4),
    .jump_index(jump_index),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc4(if_pc4),
    .dec_ready(dec_ready),
    .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  // Memory responder: ack after lat waiting cycles, or forced.
  assign imem_ack   = force_ack | (imem_req & (wait_cnt >= lat));
  assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
    if (rst)                          ack_count <= 0;
    else if (imem_req && imem_ack)    ack_count <= ack_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dec_ready = 1'b0;
    branch_valid = 1'b0; branch_pc4 = '0; branch_imm = '0;
    jump_valid = 1'b0; jump_pc4 = '0; jump_index = '0;
    #1;
    // Reset state
    check("rst_req",    imem_req, 0);
    check("rst_valid",  if_valid, 0);
    check("rst_instr",  if_instr, 0);
    check("rst_pc4",    if_pc4, 0);
    check("rst_rcount", redirect_count, 0);
    check("rst_addr",   imem_addr, 32'h40);

    // Zero-wait memory, decode always ready: 1 instr/cycle
    tick(1); rst = 1'b0; dec_ready = 1'b1;
    tick(1);
    check("first_req",  imem_req, 1);
    check("first_addr", imem_addr, 32'h40);
    check("first_nov",  if_valid, 0);
    tick(1);
    check("s1_valid", if_valid, 1);
    check("s1_instr", if_instr, 32'hDEAD_0040);
    check("s1_pc4",   if_pc4, 32'h44);
    check("s1_addr",  imem_addr, 32'h44);
    tick(1);
    check("s2_instr", if_instr, 32'hDEAD_0044);
    check("s2_pc4",   if_pc4, 32'h48);
    check("s2_addr",  imem_addr, 32'h48);

    // Decode stalled: buffer fills after exactly 4 acks
    dec_ready = 1'b0;
    apply_reset();
    tick(8);
    check("full_acks",  ack_count, 4);
    check("full_req",   imem_req, 0);
    check("full_valid", if_valid, 1);
    check("full_pc4",   if_pc4, 32'h44);
    check("full_instr", if_instr, 32'hDEAD_0040);
    check("full_addr",  imem_addr, 32'h50);
    dec_ready = 1'b1;
    tick(1);
    dec_ready = 1'b0;
    check("pop1_pc4", if_pc4, 32'h48);
    check("pop1_req", imem_req, 1);
    check("pop1_addr", imem_addr, 32'h50);
    tick(3);
    check("pop1_acks", ack_count, 5);
    check("pop1_idle", imem_req, 0);

    // Taken branch with negative immediate: 0x100 + (-4 << 2) = 0xF0
    dec_ready = 1'b1;
    apply_reset();
    tick(3);
    check("pre_br_valid", if_valid, 1);
    branch_valid = 1'b1; branch_pc4 = 32'h100; branch_imm = 32'hFFFF_FFFC;
    tick(1);
    branch_valid = 1'b0;
    check("br_addr",   imem_addr, 32'h0F0);
    check("br_flush",  if_valid, 0);
    check("br_req",    imem_req, 1);
    check("br_rcount", redirect_count, 1);
    tick(1);
    check("br_pc4",   if_pc4, 32'h0F4);
    check("br_instr", if_instr, 32'hDEAD_00F0);

    // Jump and branch together: jump wins, target 0x1000_0040
    jump_valid = 1'b1; jump_pc4 = 32'h1000_0004; jump_index = 26'h000_0010;
    branch_valid = 1'b1;
    tick(1);
    jump_valid = 1'b0; branch_valid = 1'b0;
    check("jb_addr",   imem_addr, 32'h1000_0040);
    check("jb_flush",  if_valid, 0);
    check("jb_rcount", redirect_count, 2);
    tick(1);
    check("jb_pc4",   if_pc4, 32'h1000_0044);
    check("jb_instr", if_instr, 32'hCEAD_0040);

    // Redirect during a 3-cycle-latency request to 0x20
    apply_reset();
    tick(1);
    jump_valid = 1'b1; jump_pc4 = 32'h0000_0004; jump_index = 26'h8;
    tick(1);
    jump_valid = 1'b0; lat = 2;
    check("lat_addr20", imem_addr, 32'h20);
    check("lat_req",    imem_req, 1);
    tick(1);
    jump_valid = 1'b1; jump_pc4 = 32'h2000_0000; jump_index = 26'h100;
    tick(1);
    jump_valid = 1'b0;
    check("drop_addr",   imem_addr, 32'h20);
    check("drop_req",    imem_req, 1);
    check("drop_valid",  if_valid, 0);
    check("drop_rcount", redirect_count, 2);
    tick(1);
    check("drop_gone",  if_valid, 0);
    check("drop_tgt",   imem_addr, 32'h2000_0400);
    check("drop_req2",  imem_req, 1);
    tick(2);
    check("tgt_wait", if_valid, 0);
    tick(1);
    check("tgt_valid", if_valid, 1);
    check("tgt_pc4",   if_pc4, 32'h2000_0404);

    // Reset while a request is pending; late ack is ignored
    rst = 1'b1;
    #1;
    check("mid_req",    imem_req, 0);
    check("mid_valid",  if_valid, 0);
    check("mid_instr",  if_instr, 0);
    check("mid_pc4",    if_pc4, 0);
    check("mid_rcount", redirect_count, 0);
    tick(1);
    rst = 1'b0; force_ack = 1'b1; lat = 0;
    tick(1);
    force_ack = 1'b0;
    check("late_valid", if_valid, 0);
    check("late_addr",  imem_addr, 32'h40);
    check("late_req",   imem_req, 1);
    tick(1);
    check("restart_pc4", if_pc4, 32'h44);

    // Redirect counter saturation
    apply_reset();
    branch_valid = 1'b1; branch_pc4 = 32'h200; branch_imm = 32'h0;
    tick(65534);
    check("sat_fffe", redirect_count, 16'hFFFE);
    tick(1);
    check("sat_ffff", redirect_count, 16'hFFFF);
    tick(1);
    check("sat_hold", redirect_count, 16'hFFFF);
    branch_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
